// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch controller.
//   - default address / data widths
//   - HALT opcode value
//   - FSM state enumeration (ST_ERROR exists only when FETCH_PARITY_EN is defined)
package fetch_pkg;

    localparam int unsigned ADDR_W_DEF = 12;
    localparam int unsigned DATA_W_DEF = 8;

    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_PRESENT,
        ST_ADVANCE
`ifdef FETCH_PARITY_EN
        ,
        ST_ERROR
`endif
    } state_t;

endpackage

// File: rtl/fetch_parity.sv
// fetch_parity: combinational parity checker for one ROM word.
//   i_data [DATA_W] : ROM word
//   i_par  [1]      : stored parity bit (even parity over word + bit)
//   o_err  [1]      : high when the XOR of all DATA_W+1 bits is 1
// Only instantiated when FETCH_PARITY_EN is defined.
module fetch_parity #(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_par,
    output logic              o_err
);

    assign o_err = ^{i_data, i_par};

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer between an external program
// counter, a synchronous ROM and a valid/ready downstream consumer.
//
// Ports:
//   clk, rst         : clock (rising edge), asynchronous active-high reset
//   start            : begin fetching from pc (sampled only in IDLE)
//   pc       [ADDR_W]: current value of the upstream program counter
//   pc_inc           : one-cycle counter-enable pulse after a non-HALT transfer
//   rom_rd           : ROM read strobe
//   rom_addr [ADDR_W]: ROM address (pc while reading, 0 otherwise)
//   rom_data [DATA_W]: ROM word, valid the cycle after rom_rd
//   instr  [DATA_W/2]: registered opcode (upper half of the word)
//   oprnd  [DATA_W/2]: registered operand (lower half of the word)
//   valid / ready    : downstream handshake, transfer when both high at a clock edge
//   busy             : high in every state except IDLE
//   rom_par, par_err : only with FETCH_PARITY_EN; parity input and sticky error flag
//
// Build option: define FETCH_PARITY_EN to add ROM parity checking and the
// ERROR state (left only through rst).
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   pc,
    output logic                pc_inc,
    output logic                rom_rd,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [DATA_W-1:0]   rom_data,
`ifdef FETCH_PARITY_EN
    input  logic                rom_par,
    output logic                par_err,
`endif
    output logic [DATA_W/2-1:0] instr,
    output logic [DATA_W/2-1:0] oprnd,
    output logic                valid,
    input  logic                ready,
    output logic                busy
);

    localparam int unsigned  HALF   = DATA_W / 2;
    localparam logic [HALF-1:0] L_HALT = HALF'(OP_HALT);

    state_t              r_state;
    logic                r_pc_inc;
    logic                r_rom_rd;
    logic [HALF-1:0]     r_instr;
    logic [HALF-1:0]     r_oprnd;
    logic                r_valid;
    logic                r_busy;
    logic [ADDR_W-1:0]   w_rom_addr;
    logic                w_word_bad;

`ifdef FETCH_PARITY_EN
    logic                r_par_err;

    fetch_parity #(
        .DATA_W (DATA_W)
    ) u_parity (
        .i_data (rom_data),
        .i_par  (rom_par),
        .o_err  (w_word_bad)
    );

    assign par_err = r_par_err;
`else
    assign w_word_bad = 1'b0;
`endif

    // rom_addr is decoded from the state rather than registered: READ
    // following ADVANCE must show the pc value the counter produced on the
    // same edge that entered READ.
    always_comb begin
        w_rom_addr = '0;
        if (r_state == ST_READ) begin
            w_rom_addr = pc;
        end
    end

    // Single FSM process; every output flag is registered together with the
    // state it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pc_inc  <= 1'b0;
            r_rom_rd  <= 1'b0;
            r_instr   <= '0;
            r_oprnd   <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
`ifdef FETCH_PARITY_EN
            r_par_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state  <= ST_READ;
                        r_rom_rd <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                ST_READ: begin
                    r_state  <= ST_WAIT;
                    r_rom_rd <= 1'b0;
                end
                ST_WAIT: begin
                    if (w_word_bad) begin
`ifdef FETCH_PARITY_EN
                        r_state   <= ST_ERROR;
                        r_par_err <= 1'b1;
`endif
                    end else begin
                        r_state <= ST_PRESENT;
                        r_instr <= rom_data[DATA_W-1:HALF];
                        r_oprnd <= rom_data[HALF-1:0];
                        r_valid <= 1'b1;
                    end
                end
                ST_PRESENT: begin
                    if (ready) begin
                        r_valid <= 1'b0;
                        if (r_instr == L_HALT) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state  <= ST_ADVANCE;
                            r_pc_inc <= 1'b1;
                        end
                    end
                end
                ST_ADVANCE: begin
                    r_state  <= ST_READ;
                    r_pc_inc <= 1'b0;
                    r_rom_rd <= 1'b1;
                end
`ifdef FETCH_PARITY_EN
                ST_ERROR: begin
                    r_state <= ST_ERROR;
                end
`endif
                default: begin
                    r_state  <= ST_IDLE;
                    r_pc_inc <= 1'b0;
                    r_rom_rd <= 1'b0;
                    r_valid  <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign pc_inc   = r_pc_inc;
    assign rom_rd   = r_rom_rd;
    assign rom_addr = w_rom_addr;
    assign instr    = r_instr;
    assign oprnd    = r_oprnd;
    assign valid    = r_valid;
    assign busy     = r_busy;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: self-checking bench for fetch_ctrl.
// Models the upstream program counter and a synchronous ROM, runs directed
// scenarios (reset, basic fetch, backpressure, HALT/resume, wrap, reset
// mid-fetch, parity error when FETCH_PARITY_EN is defined) and randomized
// programs checked against a transaction-level expectation: the words from
// the start pc up to and including the first HALT, in order, with one
// counter increment after every non-HALT transfer.
module tb_fetch_ctrl;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 8;
    localparam int unsigned HW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          ready;
    logic [AW-1:0] pc;
    logic          pc_inc;
    logic          rom_rd;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic [HW-1:0] instr;
    logic [HW-1:0] oprnd;
    logic          valid;
    logic          busy;
`ifdef FETCH_PARITY_EN
    logic          rom_par;
    logic          par_err;
`endif
    logic          par_ovr_en;
    logic          par_ovr;

    logic [DW-1:0] rom [4096];
    logic          ld;
    logic [AW-1:0] ld_val;

    int            n_checks = 0;
    int            n_errors = 0;

    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] w;
    int unsigned   base;
    int unsigned   len;
    int unsigned   cycles;
    logic          exp_inc;

    fetch_ctrl #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pc       (pc),
        .pc_inc   (pc_inc),
        .rom_rd   (rom_rd),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
`ifdef FETCH_PARITY_EN
        .rom_par  (rom_par),
        .par_err  (par_err),
`endif
        .instr    (instr),
        .oprnd    (oprnd),
        .valid    (valid),
        .ready    (ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Upstream 12-bit program counter: bench can load it, DUT increments it.
    always @(posedge clk) begin
        if (ld) pc <= ld_val;
        else if (pc_inc) pc <= pc + 1'b1;
    end

    // Synchronous ROM: word appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (rom_rd) begin
            rom_data <= rom[rom_addr];
`ifdef FETCH_PARITY_EN
            rom_par  <= par_ovr_en ? par_ovr : ^rom[rom_addr];
`endif
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_pc(input logic [AW-1:0] v);
        ld     = 1'b1;
        ld_val = v;
        step();
        ld     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ready = 1'b0; ld = 1'b0; ld_val = '0;
        par_ovr_en = 1'b0; par_ovr = 1'b0;
        for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);

        // ---------------- reset state ----------------
        step(); step();
        check("rst_pc_inc", pc_inc, 0);
        check("rst_rom_rd", rom_rd, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_instr", instr, 0);
        check("rst_oprnd", oprnd, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
`ifdef FETCH_PARITY_EN
        check("rst_par_err", par_err, 0);
`endif
        rst = 1'b0;
        step(); step();
        check("idle_after_rst_busy", busy, 0);
        check("idle_after_rst_rd", rom_rd, 0);

        // ---------------- basic fetch + HALT + resume ----------------
        rom[12'h010] = 8'h3A;
        rom[12'h011] = 8'hF0;
        load_pc(12'h010);
        ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("basic_c1_rd", rom_rd, 1);
        check("basic_c1_addr", rom_addr, 12'h010);
        check("basic_c1_busy", busy, 1);
        check("basic_c1_valid", valid, 0);
        step();
        check("basic_c2_rd", rom_rd, 0);
        check("basic_c2_valid", valid, 0);
        step();
        check("basic_c3_valid", valid, 1);
        check("basic_c3_instr", instr, 4'h3);
        check("basic_c3_oprnd", oprnd, 4'hA);
        check("basic_c3_inc", pc_inc, 0);
        step();
        check("basic_c4_inc", pc_inc, 1);
        check("basic_c4_valid", valid, 0);
        step();
        check("basic_c5_rd", rom_rd, 1);
        check("basic_c5_addr", rom_addr, 12'h011);
        check("basic_c5_inc", pc_inc, 0);
        step(); step();
        check("halt_valid", valid, 1);
        check("halt_instr", instr, 4'hF);
        check("halt_oprnd", oprnd, 4'h0);
        step();
        check("halt_after_valid", valid, 0);
        check("halt_after_busy", busy, 0);
        check("halt_after_inc", pc_inc, 0);
        step();
        check("halt_no_inc", pc_inc, 0);
        check("halt_pc_held", pc, 12'h011);
        start = 1'b1;
        step();
        start = 1'b0;
        check("resume_rd", rom_rd, 1);
        check("resume_addr", rom_addr, 12'h011);
        step(); step(); step();
        check("resume_done_busy", busy, 0);

        // ---------------- backpressure ----------------
        rom[12'h020] = 8'h5C;
        rom[12'h021] = 8'hF1;
        load_pc(12'h020);
        ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", valid, 1);
            check("bp_instr", instr, 4'h5);
            check("bp_oprnd", oprnd, 4'hC);
            check("bp_no_inc", pc_inc, 0);
            step();
        end
        ready = 1'b1;
        step();
        check("bp_release_inc", pc_inc, 1);
        check("bp_release_valid", valid, 0);
        step();
        check("bp_next_addr", rom_addr, 12'h021);
        step(); step(); step();
        check("bp_done_busy", busy, 0);

        // ---------------- wrap at 0xFFF ----------------
        rom[12'hFFF] = 8'h12;
        rom[12'h000] = 8'hF0;
        load_pc(12'hFFF);
        start = 1'b1;
        step();
        start = 1'b0;
        check("wrap_addr_fff", rom_addr, 12'hFFF);
        step(); step();
        check("wrap_instr", instr, 4'h1);
        check("wrap_oprnd", oprnd, 4'h2);
        step();
        check("wrap_inc", pc_inc, 1);
        step();
        check("wrap_rd", rom_rd, 1);
        check("wrap_addr_000", rom_addr, 12'h000);
        step(); step(); step();
        check("wrap_done_busy", busy, 0);

        // ---------------- reset mid-WAIT ----------------
        rom[12'h040] = 8'h77;
        load_pc(12'h040);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        #2 rst = 1'b1;
        #1;
        check("rstw_busy", busy, 0);
        check("rstw_rd", rom_rd, 0);
        check("rstw_addr", rom_addr, 0);
        check("rstw_instr", instr, 0);
        check("rstw_oprnd", oprnd, 0);
        check("rstw_valid", valid, 0);
        step();
        check("rstw_inc", pc_inc, 0);
        rst = 1'b0;
        step(); step(); step();
        check("rstw_stay_idle", busy, 0);
        check("rstw_no_valid", valid, 0);
        check("rstw_no_rd", rom_rd, 0);

        // ---------------- randomized programs ----------------
        for (int it = 0; it < 30; it++) begin
            base = $urandom_range(0, 4095);
            len  = $urandom_range(1, 8);
            exp_q.delete();
            for (int unsigned k = 0; k < len; k++) begin
                w = 8'($urandom);
                if (k == len - 1) w[7:4] = 4'hF;
                else if (w[7:4] == 4'hF) w[7:4] = 4'($urandom_range(0, 14));
                rom[(base + k) % 4096] = w;
                exp_q.push_back(w);
            end
            load_pc(AW'(base));
            start = 1'b1;
            step();
            start = 1'b0;
            exp_inc = 1'b0;
            cycles = 0;
            while (cycles < 200) begin
                check("rnd_pc_inc", pc_inc, exp_inc);
                if (!busy && exp_q.size() == 0) break;
                ready = 1'($urandom_range(0, 1));
                exp_inc = 1'b0;
                if (valid && ready) begin
                    if (exp_q.size() == 0) begin
                        check("rnd_extra_xfer", 1, 0);
                    end else begin
                        w = exp_q.pop_front();
                        check("rnd_instr", instr, w[7:4]);
                        check("rnd_oprnd", oprnd, w[3:0]);
                        exp_inc = (w[7:4] != 4'hF);
                    end
                end
                step();
                cycles++;
            end
            check("rnd_timeout", (cycles < 200), 1);
            check("rnd_all_words", exp_q.size(), 0);
            check("rnd_final_pc", pc, AW'((base + len - 1) % 4096));
        end
        ready = 1'b0;

`ifdef FETCH_PARITY_EN
        // ---------------- parity error ----------------
        rom[12'h030] = 8'h01;
        par_ovr_en = 1'b1;
        par_ovr    = 1'b0;
        load_pc(12'h030);
        ready = 1'b1;
        start = 1'b1;
        step(); step(); step();
        for (int k = 0; k < 4; k++) begin
            check("par_err_set", par_err, 1);
            check("par_no_valid", valid, 0);
            check("par_no_inc", pc_inc, 0);
            check("par_busy", busy, 1);
            step();
        end
        start = 1'b0;
        ready = 1'b0;
        par_ovr_en = 1'b0;
        rst = 1'b1;
        #1;
        check("par_rst_clear", par_err, 0);
        check("par_rst_busy", busy, 0);
        step();
        rst = 1'b0;
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL provide parameter ADDR_W, default 12, program counter and ROM address width.
REQ-002 SHALL provide parameter DATA_W, default 8, ROM word width; upper half is opcode, lower half is operand.
REQ-003 SHALL provide clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL provide rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL provide start  input  1  begin fetching from current pc; sampled only in IDLE.
REQ-006 SHALL provide pc  input  ADDR_W  current count from the upstream 12-bit program counter.
REQ-007 SHALL provide pc_inc  output  1  one-cycle pulse driving the counter enable.
REQ-008 SHALL provide rom_rd  output  1  ROM read strobe.
REQ-009 SHALL provide rom_addr  output  ADDR_W  ROM address.
REQ-010 SHALL provide rom_data  input  DATA_W  ROM word, valid the cycle after rom_rd.
REQ-011 SHALL provide instr  output  DATA_W/2  registered opcode.
REQ-012 SHALL provide oprnd  output  DATA_W/2  registered operand.
REQ-013 SHALL provide valid  output  1  instr/oprnd presented downstream.
REQ-014 SHALL provide ready  input  1  downstream accepts; transfer when valid and ready both high at a rising edge.
REQ-015 SHALL provide busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement states IDLE, READ, WAIT, PRESENT, ADVANCE (plus ERROR, see REQ-029).
REQ-017 IDLE: start=1 -> READ; otherwise remain.
REQ-018 READ: rom_rd=1, rom_addr=pc; unconditionally -> WAIT.
REQ-019 WAIT: capture rom_data into instr/oprnd at the end of the cycle; -> PRESENT.
REQ-020 PRESENT: valid=1, instr/oprnd stable; hold until ready=1; on transfer, opcode 4'hF (HALT) -> IDLE, any other opcode -> ADVANCE.
REQ-021 ADVANCE: pc_inc=1 for exactly one cycle; -> READ, which uses the already-updated pc.
REQ-022 Latency: valid first high in the third cycle after the edge sampling start; steady-state throughput one word per 4 cycles with ready held high.
REQ-023 ready already high when valid rises SHALL complete the transfer in that cycle (valid high one cycle).
REQ-024 pc=0xFFF SHALL be handled like any other address; pc_inc is still issued and wrap to 0x000 is the counter's job.
REQ-025 HALT SHALL be presented and transferred like any other instruction, with no pc_inc afterwards.
REQ-026 ready and start SHALL be ignored in all states other than those named above.

Reset
REQ-027 rst=1 SHALL immediately force IDLE and pc_inc=0, rom_rd=0, rom_addr=0, instr=0, oprnd=0, valid=0, busy=0 (and par_err=0 when built in), at any point including mid-fetch.
REQ-028 After rst deasserts, the block SHALL remain in IDLE until start.

Configuration
REQ-029 Macro FETCH_PARITY_EN defined: add input rom_par (1) and output par_err (1); in WAIT, if the XOR of rom_data and rom_par is 1 -> ERROR; ERROR holds valid=0, pc_inc=0, par_err=1, busy=1 until rst.
REQ-030 Macro FETCH_PARITY_EN undefined: rom_par, par_err and ERROR SHALL be absent, and WAIT always proceeds to PRESENT.

Structure
REQ-031 Package fetch_pkg SHALL hold the state enumeration, OP_HALT=4'hF, and default widths.
REQ-032 Parity check SHALL be a sub-module fetch_parity (combinational, DATA_W+1 inputs, 1-bit error), instantiated only under FETCH_PARITY_EN.

Verification
REQ-033 Reset: rst pulsed mid-WAIT -> next cycle all outputs 0, state IDLE, no pc_inc.
REQ-034 Basic fetch: pc=0x010, rom_data=8'h3A, start pulse, ready=1 -> rom_rd at cycle 1 with rom_addr=0x010; valid at cycle 3 with instr=3 and oprnd=A; pc_inc at cycle 4.
REQ-035 Backpressure: ready=0 for 5 cycles during PRESENT -> valid and instr/oprnd stable for all 5 cycles, no pc_inc; ready=1 -> pc_inc the next cycle.
REQ-036 HALT: rom_data=8'hF0 -> presented, transferred, no pc_inc, busy drops, second start resumes at the same pc.
REQ-037 Wrap: pc=0xFFF, rom_data=8'h12 -> pc_inc issued; next READ shows rom_addr=0x000 from the counter.
REQ-038 Parity (FETCH_PARITY_EN): rom_data=8'h01, rom_par=0 -> ERROR, par_err=1, valid never asserts, cleared only by rst.
